// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the
// MEM-stage core port (fixed priority) and a debug/loader port. A starvation
// counter lets debug steal one slot after STARVE_LIMIT lost cycles, and debug
// may lock the RAM for an exclusive back-to-back burst.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    // core (MEM stage)
    input  logic              core_read,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    // debug / loader
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    // RAM
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    // one RAM access as seen by the mux
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             core_req;
    logic             core_win;
    logic             dbg_win;
    ram_req_t         core_rq, dbg_rq, ram_rq;

    // a simultaneous read+write from the core is treated as a write
    assign core_req = core_read | core_write;
    assign core_rq  = '{we: core_write, addr: core_addr, wdata: core_wdata};
    assign dbg_rq   = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_ARB;
        else        state <= state_nxt;
    end

    // winner selection and next state; nothing is issued while reset is held
    always_comb begin
        core_win  = 1'b0;
        dbg_win   = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_ARB: begin
                if (dbg_req && (!core_req || starve_cnt == CNT_MAX)) begin
                    dbg_win = 1'b1;
                    if (dbg_lock) state_nxt = ST_LOCKED;
                end else if (core_req) begin
                    core_win = 1'b1;
                end
            end
            ST_LOCKED: begin
                // the final access (req dropped or lock released) still issues
                dbg_win = dbg_req;
                if (!dbg_req || !dbg_lock) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
        if (!reset) begin
            core_win = 1'b0;
            dbg_win  = 1'b0;
        end
    end

    // starvation counter: saturating count of dbg cycles spent waiting
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (state == ST_LOCKED || !dbg_req || dbg_win)
            starve_cnt_nxt = '0;
        else if (starve_cnt != CNT_MAX)
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    // counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) starve_cnt <= '0;
        else        starve_cnt <= starve_cnt_nxt;
    end

    // RAM mux: idle cycles still show the core fields, with we forced low
    always_comb begin
        ram_rq = dbg_win ? dbg_rq : core_rq;
        ram_en = core_win | dbg_win;
        ram_we = ram_en & ram_rq.we;
    end

    assign ram_addr   = ram_rq.addr;
    assign ram_wdata  = ram_rq.wdata;
    assign core_stall = core_req & ~core_win & reset;
    assign dbg_gnt    = dbg_win;

    // read-valid tracking: the RAM returns data one cycle after an issued read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_win & ~core_write;
            dbg_rvalid  <= dbg_win & ~dbg_we;
        end
    end

    assign core_rdata = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule
